// File: rtl/rst_seq.sv
// Sequential reset release: stage k leaves reset after a fixed delay, then waits for its ready ack or a timeout.
// A software request re-asserts the stages in reverse order, holds them, then repeats the release. Outputs are registered.
module rst_seq #(
    parameter int NUM_STAGES    = 4,
    parameter int STAGE_DELAY_p = 16,
    parameter int RDY_TIMEOUT_p = 1024,
    parameter int SW_RST_HOLD_p = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sw_rst_req,
    input  logic [NUM_STAGES-1:0] i_stage_rdy,
    output logic [NUM_STAGES-1:0] o_stage_rst_n,
    output logic                  o_all_released,
    output logic                  o_timeout,
    output logic                  o_busy
);

    localparam int CNT_MAX = (STAGE_DELAY_p > SW_RST_HOLD_p) ? STAGE_DELAY_p : SW_RST_HOLD_p;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TCNT_W  = $clog2(RDY_TIMEOUT_p + 1);
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0]  DELAY_END = CNT_W'(STAGE_DELAY_p - 1);
    localparam logic [CNT_W-1:0]  HOLD_END  = CNT_W'(SW_RST_HOLD_p - 1);
    localparam logic [TCNT_W-1:0] TOUT_END  = TCNT_W'(RDY_TIMEOUT_p - 1);

    typedef enum logic [2:0] {
        DELAY,
        WAIT_RDY,
        RUN,
        ASSERT,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
    logic                  all_rel_q, all_rel_d;
    logic                  timeout_q, timeout_d;
    logic [NUM_STAGES-1:0] idx_oh;
    logic                  rdy_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= DELAY;
            idx_q     <= '0;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            rst_n_q   <= '0;
            all_rel_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            rst_n_q   <= rst_n_d;
            all_rel_q <= all_rel_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        rst_n_d   = rst_n_q;
        all_rel_d = all_rel_q;
        timeout_d = timeout_q;
        idx_oh    = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            idx_oh[i] = (idx_q == IDX_W'(i));
        end
        // Only the ack of the stage currently being released matters.
        rdy_sel = |(i_stage_rdy & idx_oh);

        case (state_q)
            DELAY: begin
                if (cnt_q == DELAY_END) begin
                    rst_n_d = rst_n_q | idx_oh;
                    cnt_d   = '0;
                    state_d = WAIT_RDY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RDY: begin
                if (rdy_sel || (tcnt_q == TOUT_END)) begin
                    timeout_d = timeout_q | ~rdy_sel;
                    tcnt_d    = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d   = RUN;
                        all_rel_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = DELAY;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RUN: begin
                if (i_sw_rst_req) begin
                    state_d   = ASSERT;
                    idx_d     = LAST_IDX;
                    all_rel_d = 1'b0;
                end
            end
            ASSERT: begin
                rst_n_d = rst_n_q & ~idx_oh;
                if (idx_q == '0) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_END) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = DELAY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = DELAY;
        endcase
    end

    assign o_stage_rst_n  = rst_n_q;
    assign o_all_released = all_rel_q;
    assign o_timeout      = timeout_q;
    assign o_busy         = (state_q != RUN);

endmodule

// File: tb/tb_rst_seq.sv
// Directed vector bench for rst_seq with a shortened ready timeout of 64 cycles.
module tb_rst_seq;

    logic       clk;
    logic       rst;
    logic       sw_req;
    logic [3:0] rdy;
    logic [3:0] stage_rst_n;
    logic       all_rel;
    logic       tout;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    rst_seq #(
        .NUM_STAGES   (4),
        .STAGE_DELAY_p(16),
        .RDY_TIMEOUT_p(64),
        .SW_RST_HOLD_p(32)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sw_rst_req  (sw_req),
        .i_stage_rdy   (rdy),
        .o_stage_rst_n (stage_rst_n),
        .o_all_released(all_rel),
        .o_timeout     (tout),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       sw;
        logic [3:0] rdy;
        int         cyc;
        logic [3:0] e_rstn;
        logic       e_all;
        logic       e_to;
        logic       e_busy;
        string      name;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic s, input logic [3:0] rd, input int c,
                       input logic [3:0] en, input logic ea, input logic et, input logic eb,
                       input string nm);
        vec_t v;
        v.rst = r; v.sw = s; v.rdy = rd; v.cyc = c;
        v.e_rstn = en; v.e_all = ea; v.e_to = et; v.e_busy = eb; v.name = nm;
        vq.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [6:0] exp);
        logic [6:0] got;
        got = {stage_rst_n, all_rel, tout, busy};
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got rst_n=%b all=%b to=%b busy=%b, expected rst_n=%b all=%b to=%b busy=%b",
                      nm, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
    endtask

    task automatic apply(input vec_t v);
        rst    = v.rst;
        sw_req = v.sw;
        rdy    = v.rdy;
        step(v.cyc);
        chk(v.name, {v.e_rstn, v.e_all, v.e_to, v.e_busy});
    endtask

    int p1;
    logic [3:0] exp_n;

    initial begin
        rst = 1'b1; sw_req = 1'b0; rdy = 4'b1111;

        // Power-up release, all acks immediate: releases at 16, 33, 50, 67; RUN at 68.
        add(1, 0, 4'b1111,  2, 4'b0000, 0, 0, 1, "reset_state");
        add(0, 0, 4'b1111, 15, 4'b0000, 0, 0, 1, "pre_s0");
        add(0, 0, 4'b1111,  1, 4'b0001, 0, 0, 1, "rel_s0");
        add(0, 0, 4'b1111, 16, 4'b0001, 0, 0, 1, "pre_s1");
        add(0, 0, 4'b1111,  1, 4'b0011, 0, 0, 1, "rel_s1");
        add(0, 0, 4'b1111, 17, 4'b0111, 0, 0, 1, "rel_s2");
        add(0, 0, 4'b1111, 16, 4'b0111, 0, 0, 1, "pre_s3");
        add(0, 0, 4'b1111,  1, 4'b1111, 0, 0, 1, "rel_s3");
        add(0, 0, 4'b1111,  1, 4'b1111, 1, 0, 0, "all_released");
        add(0, 0, 4'b1111,  5, 4'b1111, 1, 0, 0, "run_steady");
        p1 = vq.size();

        // After the reverse cascade (edge E+4): pulses in HOLD and DELAY are ignored.
        add(0, 0, 4'b1111,  5, 4'b0000, 0, 0, 1, "hold");
        add(0, 1, 4'b1111,  1, 4'b0000, 0, 0, 1, "sw_in_hold");
        add(0, 0, 4'b1111, 29, 4'b0000, 0, 0, 1, "hold_to_delay");
        add(0, 1, 4'b1111,  1, 4'b0000, 0, 0, 1, "sw_in_delay");
        add(0, 0, 4'b1111, 11, 4'b0000, 0, 0, 1, "pre_rerel_s0");
        add(0, 0, 4'b1111,  1, 4'b0001, 0, 0, 1, "rerel_s0");
        add(0, 0, 4'b1111, 17, 4'b0011, 0, 0, 1, "rerel_s1");
        add(0, 0, 4'b1111, 17, 4'b0111, 0, 0, 1, "rerel_s2");
        add(0, 0, 4'b1111, 17, 4'b1111, 0, 0, 1, "rerel_s3");
        add(0, 0, 4'b1111,  1, 4'b1111, 1, 0, 0, "rerel_all");

        // Stage 2 ack withheld: timeout on the 64th wait cycle (edge 114), stage 3 at 130.
        add(1, 1, 4'b1011,  1, 4'b0000, 0, 0, 1, "rst_with_sw");
        add(0, 0, 4'b1011, 50, 4'b0111, 0, 0, 1, "to_s2_rel");
        add(0, 0, 4'b1011, 63, 4'b0111, 0, 0, 1, "to_not_yet");
        add(0, 0, 4'b1011,  1, 4'b0111, 0, 1, 1, "to_set");
        add(0, 0, 4'b1011, 15, 4'b0111, 0, 1, 1, "to_pre_s3");
        add(0, 0, 4'b1011,  1, 4'b1111, 0, 1, 1, "to_rel_s3");
        add(0, 0, 4'b1011,  1, 4'b1111, 1, 1, 0, "to_all");
        add(0, 1, 4'b1011,  1, 4'b1111, 0, 1, 1, "to_sw_req");
        add(0, 0, 4'b1011,  4, 4'b0000, 0, 1, 1, "to_cascade");
        add(0, 0, 4'b1011, 48, 4'b0001, 0, 1, 1, "to_rerel_s0");
        add(0, 0, 4'b1011, 34, 4'b0111, 0, 1, 1, "to_rerel_s2");
        add(0, 0, 4'b1011,  4, 4'b0111, 0, 1, 1, "wait_idx2");

        // Reset while waiting on stage 2 clears everything and restarts from stage 0.
        add(1, 0, 4'b1011,  1, 4'b0000, 0, 0, 1, "rst_in_wait");
        add(0, 0, 4'b1111, 15, 4'b0000, 0, 0, 1, "restart_pre_s0");
        add(0, 0, 4'b1111,  1, 4'b0001, 0, 0, 1, "restart_s0");

        // Early rdy[3] while waiting on stage 1; stage 1 ack arrives on the timeout cycle.
        add(0, 0, 4'b1001, 17, 4'b0011, 0, 0, 1, "early3_s1");
        add(0, 0, 4'b1001, 63, 4'b0011, 0, 0, 1, "early3_ignored");
        add(0, 0, 4'b1111,  1, 4'b0011, 0, 0, 1, "rdy_at_timeout");
        add(0, 0, 4'b1111, 16, 4'b0111, 0, 0, 1, "late_s2");
        add(0, 0, 4'b1111, 17, 4'b1111, 0, 0, 1, "late_s3");
        add(0, 0, 4'b1111,  1, 4'b1111, 1, 0, 0, "late_all");

        for (int i = 0; i < p1; i++) apply(vq[i]);

        // Software request in RUN: release flag drops at once, stages re-assert high to low.
        sw_req = 1'b1;
        step(1);
        chk("sw_req_run", {4'b1111, 1'b0, 1'b0, 1'b1});
        sw_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            exp_n = 4'b1111 >> (i + 1);
            chk($sformatf("cascade_%0d", i), {exp_n, 1'b0, 1'b0, 1'b1});
        end

        for (int i = p1; i < vq.size(); i++) apply(vq[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
